// File: rtl/point_update_scheduler.sv
// Per-frame walker over the point register file, feeding one shared update_point.
// Optional SCHED_TIMEOUT_EN bounds each WAIT to TIMEOUT cycles.
module point_update_scheduler #(
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int NUM_POINTS    = 4,
    parameter int TIMEOUT       = 64,
    localparam int IDX_W = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     frame_start_in,
    input  logic                     load_valid_in,
    input  logic [IDX_W-1:0]         load_idx_in,
    input  logic [POSITION_SIZE-1:0] load_pos_x_in,
    input  logic [POSITION_SIZE-1:0] load_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] load_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] load_vel_y_in,
    input  logic [IDX_W-1:0]         rd_idx_in,
    output logic [POSITION_SIZE-1:0] rd_pos_x_out,
    output logic [POSITION_SIZE-1:0] rd_pos_y_out,
    output logic                     begin_out,
    output logic [POSITION_SIZE-1:0] pos_x_out,
    output logic [POSITION_SIZE-1:0] pos_y_out,
    output logic [VELOCITY_SIZE-1:0] vel_x_out,
    output logic [VELOCITY_SIZE-1:0] vel_y_out,
    input  logic                     result_in,
    input  logic [POSITION_SIZE-1:0] new_pos_x_in,
    input  logic [POSITION_SIZE-1:0] new_pos_y_in,
    input  logic [VELOCITY_SIZE-1:0] new_vel_x_in,
    input  logic [VELOCITY_SIZE-1:0] new_vel_y_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     overrun_out,
    output logic                     timeout_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic overrun_q;
    logic wr_en, load_en, last, tmo_hit;

    logic [POSITION_SIZE-1:0] px_q [NUM_POINTS];
    logic [POSITION_SIZE-1:0] py_q [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vx_q [NUM_POINTS];
    logic [VELOCITY_SIZE-1:0] vy_q [NUM_POINTS];

    assign busy_out    = (state_q != IDLE);
    assign overrun_out = overrun_q;
    assign load_en     = load_valid_in && (state_q == IDLE);
    assign last        = (idx_q == IDX_W'(NUM_POINTS - 1));

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wcnt_q;
    logic timeout_q;

    // A same-cycle result wins over the timeout.
    assign tmo_hit = (state_q == WAIT) && !result_in &&
                     (wcnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_out = timeout_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)
                wcnt_q <= '0;
            else if (state_q == WAIT)
                wcnt_q <= wcnt_q + CNT_W'(1);
            if (tmo_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
    assign timeout_out    = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (frame_start_in && busy_out)
                overrun_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_en     = 1'b0;
        begin_out = 1'b0;
        done_out  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                begin_out = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                wr_en = result_in;
                if (result_in || tmo_hit) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                done_out = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                if (load_en && load_idx_in == IDX_W'(i)) begin
                    px_q[i] <= load_pos_x_in;
                    py_q[i] <= load_pos_y_in;
                    vx_q[i] <= load_vel_x_in;
                    vy_q[i] <= load_vel_y_in;
                end else if (wr_en && idx_q == IDX_W'(i)) begin
                    px_q[i] <= new_pos_x_in;
                    py_q[i] <= new_pos_y_in;
                    vx_q[i] <= new_vel_x_in;
                    vy_q[i] <= new_vel_y_in;
                end
            end
        end
    end

    // Index decode by match so out-of-range indices fall through to zero.
    always_comb begin
        rd_pos_x_out = '0;
        rd_pos_y_out = '0;
        pos_x_out    = '0;
        pos_y_out    = '0;
        vel_x_out    = '0;
        vel_y_out    = '0;
        for (int i = 0; i < NUM_POINTS; i++) begin
            if (rd_idx_in == IDX_W'(i)) begin
                rd_pos_x_out = px_q[i];
                rd_pos_y_out = py_q[i];
            end
            if (idx_q == IDX_W'(i)) begin
                pos_x_out = px_q[i];
                pos_y_out = py_q[i];
                vel_x_out = vx_q[i];
                vel_y_out = vy_q[i];
            end
        end
    end

endmodule

// File: tb/tb_point_update_scheduler.sv
// Bench for point_update_scheduler: vector table for load/read, scoreboard
// of issues and done pulses against a stub update_point (L=3, pos+=vel).
module tb_point_update_scheduler;

    localparam int NP  = 4;
    localparam int L   = 3;
    localparam int TMO = 8;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       frame_start_in;
    logic       load_valid_in;
    logic [1:0] load_idx_in;
    logic [7:0] load_pos_x_in, load_pos_y_in;
    logic [7:0] load_vel_x_in, load_vel_y_in;
    logic [1:0] rd_idx_in;
    logic [7:0] rd_pos_x_out, rd_pos_y_out;
    logic       begin_out;
    logic [7:0] pos_x_out, pos_y_out, vel_x_out, vel_y_out;
    logic       result_in;
    logic [7:0] new_pos_x_in, new_pos_y_in;
    logic [7:0] new_vel_x_in, new_vel_y_in;
    logic       busy_out, done_out, overrun_out, timeout_out;

    logic       stub_res, man_res, stub_en;
    logic [7:0] s_px, s_py, s_vx, s_vy;
    logic [7:0] c_px, c_py, c_vx, c_vy;
    logic [7:0] man_v;
    int         stub_cnt, issue_n, skip_idx;

    int total, bad;
    int cyc_cnt, start_cyc, done_count;

    logic [7:0] m_px[NP], m_py[NP], m_vx[NP], m_vy[NP];

    typedef struct {
        int cyc;
        logic [7:0] px, py, vx, vy;
    } iss_t;

    iss_t exp_q[$];
    int   exp_done_q[$];

    typedef struct packed {
        logic       ld;
        logic [1:0] idx;
        logic [7:0] px, py, vx, vy;
        logic [1:0] rd;
        logic [7:0] ex, ey;
    } vec_t;

    vec_t vt[4];

    assign result_in    = stub_res | man_res;
    assign new_pos_x_in = man_res ? man_v : s_px;
    assign new_pos_y_in = man_res ? man_v : s_py;
    assign new_vel_x_in = man_res ? man_v : s_vx;
    assign new_vel_y_in = man_res ? man_v : s_vy;

    point_update_scheduler #(
        .POSITION_SIZE(8),
        .VELOCITY_SIZE(8),
        .NUM_POINTS(NP),
        .TIMEOUT(TMO)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .frame_start_in(frame_start_in),
        .load_valid_in(load_valid_in),
        .load_idx_in(load_idx_in),
        .load_pos_x_in(load_pos_x_in),
        .load_pos_y_in(load_pos_y_in),
        .load_vel_x_in(load_vel_x_in),
        .load_vel_y_in(load_vel_y_in),
        .rd_idx_in(rd_idx_in),
        .rd_pos_x_out(rd_pos_x_out),
        .rd_pos_y_out(rd_pos_y_out),
        .begin_out(begin_out),
        .pos_x_out(pos_x_out),
        .pos_y_out(pos_y_out),
        .vel_x_out(vel_x_out),
        .vel_y_out(vel_y_out),
        .result_in(result_in),
        .new_pos_x_in(new_pos_x_in),
        .new_pos_y_in(new_pos_y_in),
        .new_vel_x_in(new_vel_x_in),
        .new_vel_y_in(new_vel_y_in),
        .busy_out(busy_out),
        .done_out(done_out),
        .overrun_out(overrun_out),
        .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc_cnt++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stub update_point: answers L cycles after begin with pos+vel.
    always @(negedge clk_in) begin
        stub_res = 1'b0;
        if (!stub_en) begin
            stub_cnt = 0;
        end else if (begin_out) begin
            if (issue_n != skip_idx) begin
                c_px = pos_x_out;
                c_py = pos_y_out;
                c_vx = vel_x_out;
                c_vy = vel_y_out;
                stub_cnt = L;
            end
            issue_n++;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                stub_res = 1'b1;
                s_px = c_px + c_vx;
                s_py = c_py + c_vy;
                s_vx = c_vx;
                s_vy = c_vy;
            end
        end
    end

    // Scoreboard: pop expected issues and done pulses as they appear.
    always @(negedge clk_in) begin
        int   rel;
        iss_t e;
        rel = cyc_cnt - start_cyc + 1;
        if (begin_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_begin: got begin at %0d want none",
                         rel);
            end else begin
                e = exp_q.pop_front();
                chk("begin_cycle", rel, e.cyc);
                chk("issue_px", pos_x_out, e.px);
                chk("issue_py", pos_y_out, e.py);
                chk("issue_vx", vel_x_out, e.vx);
                chk("issue_vy", vel_y_out, e.vy);
            end
        end
        if (done_out) begin
            done_count++;
            if (exp_done_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done at %0d want none",
                         rel);
            end else begin
                chk("done_cycle", rel, exp_done_q.pop_front());
            end
        end
    end

    task automatic check_entries(input string name);
        for (int i = 0; i < NP; i++) begin
            rd_idx_in = 2'(i);
            #1;
            chk($sformatf("%s_rd%0d_x", name, i), rd_pos_x_out, m_px[i]);
            chk($sformatf("%s_rd%0d_y", name, i), rd_pos_y_out, m_py[i]);
        end
    endtask

    task automatic check_status(input string name, input logic ov,
                                input logic to);
        chk({name, "_busy"}, busy_out, 0);
        chk({name, "_done"}, done_out, 0);
        chk({name, "_begin"}, begin_out, 0);
        chk({name, "_overrun"}, overrun_out, ov);
        chk({name, "_timeout"}, timeout_out, to);
    endtask

    task automatic do_load(input logic [1:0] i, input logic [7:0] px,
                           input logic [7:0] py, input logic [7:0] vx,
                           input logic [7:0] vy);
        @(negedge clk_in);
        load_valid_in = 1'b1;
        load_idx_in   = i;
        load_pos_x_in = px;
        load_pos_y_in = py;
        load_vel_x_in = vx;
        load_vel_y_in = vy;
        @(posedge clk_in);
        #1;
        load_valid_in = 1'b0;
        m_px[i] = px;
        m_py[i] = py;
        m_vx[i] = vx;
        m_vy[i] = vy;
    endtask

    task automatic start_pass(input int skip, input logic ld,
                              input logic [7:0] px, input logic [7:0] py,
                              input logic [7:0] vx, input logic [7:0] vy);
        int t;
        @(negedge clk_in);
        if (ld) begin
            load_valid_in = 1'b1;
            load_idx_in   = 2'd0;
            load_pos_x_in = px;
            load_pos_y_in = py;
            load_vel_x_in = vx;
            load_vel_y_in = vy;
            m_px[0] = px;
            m_py[0] = py;
            m_vx[0] = vx;
            m_vy[0] = vy;
        end
        skip_idx = skip;
        issue_n  = 0;
        t = 1;
        for (int e = 0; e < NP; e++) begin
            exp_q.push_back('{t, m_px[e], m_py[e], m_vx[e], m_vy[e]});
            t += (e == skip) ? (1 + TMO) : (1 + L);
        end
        exp_done_q.push_back(t);
        frame_start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_cyc      = cyc_cnt;
        frame_start_in = 1'b0;
        load_valid_in  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_count == d0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in);
        chk("done_seen", done_count - d0, 1);
    endtask

    task automatic finish_pass(input int skip);
        for (int e = 0; e < NP; e++) begin
            if (e != skip) begin
                m_px[e] = m_px[e] + m_vx[e];
                m_py[e] = m_py[e] + m_vy[e];
            end
        end
        chk("sb_issue_drained", exp_q.size(), 0);
        chk("sb_done_drained", exp_done_q.size(), 0);
    endtask

    initial begin
        int d0;
        total = 0;
        bad = 0;
        cyc_cnt = 0;
        start_cyc = 0;
        done_count = 0;
        stub_cnt = 0;
        issue_n = 0;
        skip_idx = -1;
        stub_en = 1'b1;
        stub_res = 1'b0;
        man_res = 1'b0;
        man_v = 8'h00;
        {s_px, s_py, s_vx, s_vy} = '0;
        {c_px, c_py, c_vx, c_vy} = '0;
        rst_in = 1'b0;
        frame_start_in = 1'b0;
        load_valid_in = 1'b0;
        load_idx_in = 2'd0;
        {load_pos_x_in, load_pos_y_in} = '0;
        {load_vel_x_in, load_vel_y_in} = '0;
        rd_idx_in = 2'd0;
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 8'h00;
            m_py[i] = 8'h00;
            m_vx[i] = 8'h00;
            m_vy[i] = 8'h00;
        end

        repeat (3) @(negedge clk_in);
        check_status("rst", 1'b0, 1'b0);
        check_entries("rst");
        rst_in = 1'b1;

        vt[0] = '{1'b1, 2'd1, 8'd2, 8'd3, 8'hFE, 8'd0, 2'd1, 8'd2, 8'd3};
        vt[1] = '{1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd0, 8'd0, 8'd0};
        vt[2] = '{1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd2, 8'd0, 8'd0};
        vt[3] = '{1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 2'd3, 8'd0, 8'd0};
        for (int r = 0; r < 4; r++) begin
            if (vt[r].ld)
                do_load(vt[r].idx, vt[r].px, vt[r].py, vt[r].vx, vt[r].vy);
            rd_idx_in = vt[r].rd;
            #1;
            chk($sformatf("vec%0d_x", r), rd_pos_x_out, vt[r].ex);
            chk($sformatf("vec%0d_y", r), rd_pos_y_out, vt[r].ey);
        end
        check_status("load", 1'b0, 1'b0);

        d0 = done_count;
        start_pass(-1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_done(d0);
        finish_pass(-1);
        check_entries("pass1");
        rd_idx_in = 2'd1;
        #1;
        chk("pass1_e1_x", rd_pos_x_out, 8'd0);
        chk("pass1_e1_y", rd_pos_y_out, 8'd3);
        check_status("pass1", 1'b0, 1'b0);

        d0 = done_count;
        start_pass(-1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (10) @(negedge clk_in);
        frame_start_in = 1'b1;
        load_valid_in  = 1'b1;
        load_idx_in    = 2'd0;
        load_pos_x_in  = 8'd9;
        load_pos_y_in  = 8'd9;
        load_vel_x_in  = 8'd0;
        load_vel_y_in  = 8'd0;
        @(posedge clk_in);
        #1;
        frame_start_in = 1'b0;
        load_valid_in  = 1'b0;
        chk("overrun_set", overrun_out, 1'b1);
        wait_done(d0);
        repeat (20) @(negedge clk_in);
        chk("overrun_one_done", done_count - d0, 1);
        chk("overrun_no_repass", busy_out, 1'b0);
        finish_pass(-1);
        check_entries("busyload");
        do_load(2'd0, 8'd9, 8'd9, 8'd0, 8'd0);
        check_entries("idleload");
        check_status("overrun", 1'b1, 1'b0);

        d0 = done_count;
        start_pass(-1, 1'b1, 8'h20, 8'h21, 8'h01, 8'h02);
        wait_done(d0);
        finish_pass(-1);
        check_entries("ldstart");

        start_pass(-1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (6) @(negedge clk_in);
        stub_en = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        check_status("arst", 1'b0, 1'b0);
        exp_q.delete();
        exp_done_q.delete();
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 8'h00;
            m_py[i] = 8'h00;
            m_vx[i] = 8'h00;
            m_vy[i] = 8'h00;
        end
        check_entries("arst");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        man_v   = 8'd5;
        man_res = 1'b1;
        @(negedge clk_in);
        man_res = 1'b0;
        stub_en = 1'b1;
        check_entries("arst_late");
        chk("arst_late_busy", busy_out, 1'b0);

`ifdef SCHED_TIMEOUT_EN
        do_load(2'd2, 8'd10, 8'd20, 8'd1, 8'd1);
        do_load(2'd3, 8'd4, 8'd4, 8'd1, 8'd1);
        d0 = done_count;
        start_pass(2, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
        wait_done(d0);
        finish_pass(2);
        skip_idx = -1;
        check_entries("tmo");
        check_status("tmo", 1'b0, 1'b1);
`else
        chk("no_timeout", timeout_out, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
